inst_encode: RTL

- Instruction encoder/loader: the inverse of the instruction decoder.
- Accepts instruction fields over a valid/ready stream, packs them into 18-bit instruction words and writes them sequentially into instruction memory from a programmed base address.
- Sits between the test/boot loader path and the instruction memory write port.
- Validates opcode and funct against the ISA; counts illegal entries and drops them.

---
 rtl/inst_encode.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/inst_encode.sv
// Instruction encoder/loader: packs field bundles into 18-bit words and
// writes them sequentially into instruction memory from a base address.
// Illegal opcode/funct bundles are consumed, counted and dropped.
module inst_encode #(
    parameter int OPCODE_WIDTH    = 4,
    parameter int FUNCTION_WIDTH  = 8,
    parameter int ADDRESS_WIDTH   = 2,
    parameter int INST_WIDTH      = 18,
    parameter int IMEM_ADDR_WIDTH = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic [IMEM_ADDR_WIDTH-1:0]           i_base_addr,
    input  logic [IMEM_ADDR_WIDTH-1:0]           i_count,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic [OPCODE_WIDTH-1:0]              i_opcode,
    input  logic [ADDRESS_WIDTH-1:0]             i_rd,
    input  logic [ADDRESS_WIDTH-1:0]             i_rs1,
    input  logic [ADDRESS_WIDTH-1:0]             i_rs2,
    input  logic [FUNCTION_WIDTH-1:0]            i_funct,
    input  logic [INST_WIDTH-OPCODE_WIDTH-1:0]   i_imm,
    output logic                                 o_wr_en,
    input  logic                                 i_mem_ready,
    output logic [IMEM_ADDR_WIDTH-1:0]           o_wr_addr,
    output logic [INST_WIDTH-1:0]                o_wr_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [IMEM_ADDR_WIDTH-1:0]           o_err_cnt
);

    localparam logic [OPCODE_WIDTH-1:0] OP_R_TYPE = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDR    = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_STR    = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI   = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI   = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE    = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP    = OPCODE_WIDTH'(6);

    localparam logic [FUNCTION_WIDTH-1:0] FN_ADD = FUNCTION_WIDTH'(8'h00);
    localparam logic [FUNCTION_WIDTH-1:0] FN_SUB = FUNCTION_WIDTH'(8'h01);
    localparam logic [FUNCTION_WIDTH-1:0] FN_AND = FUNCTION_WIDTH'(8'h02);
    localparam logic [FUNCTION_WIDTH-1:0] FN_OR  = FUNCTION_WIDTH'(8'h03);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic                          wr_en_q, wr_en_d;
    logic [IMEM_ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [INST_WIDTH-1:0]         wr_data_q, wr_data_d;
    logic [IMEM_ADDR_WIDTH-1:0]    err_cnt_q, err_cnt_d;
    logic [IMEM_ADDR_WIDTH-1:0]    remaining_q, remaining_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic                          bundle_legal;
    logic [INST_WIDTH-1:0]         encoded;
    logic                          write_accept;
    logic                          bundle_accept;
    logic                          ready;

    // Validate the incoming bundle and pack it into its instruction format
    always_comb begin
        bundle_legal = 1'b0;
        encoded      = '0;
        case (i_opcode)
            OP_R_TYPE: begin
                encoded = {i_opcode, i_rd, i_rs1, i_rs2, i_funct};
                case (i_funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR: bundle_legal = 1'b1;
                    default:                       bundle_legal = 1'b0;
                endcase
            end
            OP_LDR, OP_STR, OP_ADDI, OP_SUBI: begin
                bundle_legal = 1'b1;
                encoded      = {i_opcode, i_rd, i_rs1, {ADDRESS_WIDTH{1'b0}},
                                i_imm[FUNCTION_WIDTH-1:0]};
            end
            OP_BNE, OP_JMP: begin
                bundle_legal = 1'b1;
                encoded      = {i_opcode, i_imm};
            end
            default: begin
                bundle_legal = 1'b0;
                encoded      = '0;
            end
        endcase
    end

    // Handshakes: a new bundle may enter whenever the output slot is free or
    // being drained this cycle, which gives back-to-back throughput
    always_comb begin
        ready         = (state_q == ST_LOAD) && (remaining_q != '0) &&
                        (!wr_en_q || i_mem_ready);
        write_accept  = wr_en_q && i_mem_ready;
        bundle_accept = i_valid && ready;
    end

    // Next-state and next-output computation for the load session FSM
    always_comb begin
        state_d     = state_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_cnt_d   = err_cnt_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    wr_addr_d   = i_base_addr;
                    remaining_d = i_count;
                    err_cnt_d   = '0;
                    wr_en_d     = 1'b0;
                    state_d     = (i_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (write_accept) begin
                    wr_en_d   = 1'b0;
                    wr_addr_d = wr_addr_q + 1'b1;
                end
                if (bundle_accept) begin
                    remaining_d = remaining_q - 1'b1;
                    if (bundle_legal) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = encoded;
                    end else if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
                if ((remaining_q == '0) && (!wr_en_q || write_accept)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; reset aborts any session in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_cnt_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_cnt_q   <= err_cnt_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_ready   = ready;
    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_err_cnt = err_cnt_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule
